// File: rtl/gsr_reset_seq.sv
// Global-reset sequencer feeding the Spartan-6 startup/GSR wrapper.
// Each request runs quiesce -> GSR pulse -> recovery -> done.
module gsr_reset_seq #(
    parameter int PRE_CYCLES   = 16,
    parameter int GSR_CYCLES   = 8,
    parameter int POST_CYCLES  = 64,
    parameter int TIMEOUT_MULT = 4,
    parameter bit POR_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       quiesce_ack,
    output logic       quiesce,
    output logic       gsr,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] seq_count
);

    localparam int TO_LAST  = PRE_CYCLES * TIMEOUT_MULT - 1;
    localparam int MAX_A    = (TO_LAST > GSR_CYCLES - 1) ?
                              TO_LAST : GSR_CYCLES - 1;
    localparam int MAX_T    = (MAX_A > POST_CYCLES - 1) ?
                              MAX_A : POST_CYCLES - 1;
    localparam int CW       = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TO_LAST);
    localparam logic [CW-1:0] GSR_LAST  = CW'(GSR_CYCLES - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_QUI  = 2'd1;
    localparam logic [1:0] S_ASR  = 2'd2;
    localparam logic [1:0] S_REC  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          tmo_q, tmo_d;
    logic          done_q, done_d;
    logic [7:0]    sc_q, sc_d;
    logic          quiesce_q, gsr_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        sc_d    = sc_q;
        case (state_q)
            S_IDLE: begin
                if (req || pend_q) begin
                    state_d = S_QUI;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_QUI: begin
                cnt_d = cnt_q + 1'b1;
                if (req) pend_d = 1'b1;
                // early acks are ignored until the minimum has elapsed
                if (cnt_q >= PRE_LAST && quiesce_ack) begin
                    state_d = S_ASR;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ASR;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            S_ASR: begin
                cnt_d = cnt_q + 1'b1;
                if (req) pend_d = 1'b1;
                if (cnt_q == GSR_LAST) begin
                    state_d = S_REC;
                    cnt_d   = '0;
                end
            end
            S_REC: begin
                cnt_d = cnt_q + 1'b1;
                if (req) pend_d = 1'b1;
                if (cnt_q == POST_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (sc_q != 8'hFF) sc_d = sc_q + 8'd1;
                    // a request landing on the exit cycle chains directly
                    if (pend_q || req) begin
                        state_d = S_QUI;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= POR_EN;
            tmo_q     <= 1'b0;
            done_q    <= 1'b0;
            sc_q      <= 8'd0;
            quiesce_q <= 1'b0;
            gsr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            sc_q      <= sc_d;
            quiesce_q <= (state_d != S_IDLE);
            gsr_q     <= (state_d == S_ASR);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign quiesce   = quiesce_q;
    assign gsr       = gsr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = tmo_q;
    assign seq_count = sc_q;

endmodule

// File: tb/tb_gsr_reset_seq.sv
// Scoreboard bench for gsr_reset_seq: stimulus queues timed edge events,
// a monitor pops and compares them as the outputs move.
module tb_gsr_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       quiesce_ack;
    logic       quiesce, gsr, busy, done, timeout;
    logic [7:0] seq_count;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    localparam int QR = 0;
    localparam int GR = 1;
    localparam int GF = 2;
    localparam int DN = 3;
    localparam int QF = 4;

    typedef struct {
        int kind;
        int at;
        int sc;
        int to;
    } ev_t;

    ev_t exq[$];

    logic pq = 1'b0;
    logic pg = 1'b0;
    logic pd = 1'b0;

    gsr_reset_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .quiesce_ack(quiesce_ack),
        .quiesce    (quiesce),
        .gsr        (gsr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .seq_count  (seq_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void push(int k, int t, int s, int o);
        exq.push_back('{kind: k, at: t, sc: s, to: o});
    endfunction

    task automatic got(int k);
        ev_t e;
        total++;
        if (exq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d",
                     k, cyc);
        end else begin
            e = exq.pop_front();
            if (e.kind != k || e.at != cyc) begin
                bad++;
                $display("FAIL event: got kind %0d at %0d expected kind %0d at %0d",
                         k, cyc, e.kind, e.at);
            end
            if (k == DN && e.kind == DN) begin
                chk("seq_count", int'(seq_count), e.sc);
                chk("timeout", int'(timeout), e.to);
            end
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (quiesce && !pq) got(QR);
            if (gsr && !pg) got(GR);
            if (!gsr && pg) got(GF);
            if (done && !pd) got(DN);
            if (done) chk("done_width", int'(pd), 0);
            if (!quiesce && pq) got(QF);
            pq = quiesce;
            pg = gsr;
            pd = done;
        end
    end

    task automatic wait_to(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // One full sequence with a fixed quiesce length qlen.
    task automatic push_seq(int q, int qlen, int s, int o, bit last);
        push(GR, q + qlen, 0, 0);
        push(GF, q + qlen + 8, 0, 0);
        push(DN, q + qlen + 72, s, o);
        if (last) push(QF, q + qlen + 72, 0, 0);
    endtask

    task automatic chk_idle(string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_quiesce"}, int'(quiesce), 0);
        chk({name, "_gsr"}, int'(gsr), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        rst_n       = 1'b0;
        req         = 1'b0;
        quiesce_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_count", int'(seq_count), 0);

        // power-on request with ack tied high
        q = cyc + 1;
        rst_n = 1'b1;
        push(QR, q, 0, 0);
        push_seq(q, 16, 1, 0, 1'b1);
        #1;
        chk("por_pre_edge_quiesce", int'(quiesce), 0);
        wait_to(q + 50);
        chk("por_busy", int'(busy), 1);
        wait_to(q + 90);
        chk_idle("por_end");

        // late ack: 30 cycles into quiesce
        quiesce_ack = 1'b0;
        q = cyc + 1;
        push(QR, q, 0, 0);
        push_seq(q, 31, 2, 0, 1'b1);
        pulse_req();
        wait_to(q + 30);
        quiesce_ack = 1'b1;
        wait_to(q + 105);
        chk("late_ack_timeout", int'(timeout), 0);
        chk_idle("late_ack_end");

        // no ack except one early pulse: timeout path
        quiesce_ack = 1'b0;
        q = cyc + 1;
        push(QR, q, 0, 0);
        push_seq(q, 64, 3, 1, 1'b1);
        pulse_req();
        wait_to(q + 5);
        quiesce_ack = 1'b1;
        @(negedge clk);
        quiesce_ack = 1'b0;
        wait_to(q + 138);
        quiesce_ack = 1'b1;
        chk("tmo_sticky", int'(timeout), 1);
        chk_idle("tmo_end");

        // three requests during ASSERT/RECOVER coalesce
        q = cyc + 1;
        push(QR, q, 0, 0);
        push_seq(q, 16, 4, 1, 1'b0);
        push_seq(q + 88, 16, 5, 1, 1'b1);
        pulse_req();
        wait_to(q + 18);
        pulse_req();
        wait_to(q + 30);
        pulse_req();
        wait_to(q + 60);
        pulse_req();
        wait_to(q + 178);
        chk_idle("coalesce_end");

        // reset during the 4th ASSERT cycle
        q = cyc + 1;
        push(QR, q, 0, 0);
        push(GR, q + 16, 0, 0);
        push(GF, q + 20, 0, 0);
        push(QF, q + 20, 0, 0);
        pulse_req();
        wait_to(q + 19);
        chk("mid_gsr_high", int'(gsr), 1);
        rst_n = 1'b0;
        #1;
        chk("async_gsr", int'(gsr), 0);
        chk("async_quiesce", int'(quiesce), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_timeout", int'(timeout), 0);
        chk("async_count", int'(seq_count), 0);
        wait_to(q + 21);
        rst_n = 1'b1;
        q = q + 22;
        push(QR, q, 0, 0);
        push_seq(q, 16, 1, 0, 1'b1);
        wait_to(q + 90);
        chk_idle("por2_end");

        // 260 back-to-back sequences with req held high
        q = cyc + 1;
        push(QR, q, 0, 0);
        for (int k = 1; k <= 260; k++) begin
            push_seq(q + 88 * (k - 1), 16,
                     (k + 1 > 255) ? 255 : k + 1, 0, k == 260);
        end
        req = 1'b1;
        wait_to(q + 88 * 259);
        req = 1'b0;
        wait_to(q + 88 * 260 + 2);
        chk("sat_count", int'(seq_count), 255);
        chk_idle("sat_end");

        chk("queue_drain", exq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
